// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle ADD and WIDTH-cycle shift-add MUL behind a start/done handshake.
// result/zero/cout hold their value until the next accepted operation completes.
module mc_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_cout;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_mul_last;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == CNT_LAST);
    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Operand and multiply datapath; only meaningful while the FSM says so, hence no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, b};
            r_mplier <= a;
            r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_cout   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_state <= op ? S_MUL : S_ADD;
                    end
                end
                S_ADD: begin
                    r_result <= w_sum[WIDTH-1:0];
                    r_cout   <= w_sum[WIDTH];
                    r_zero   <= (w_sum[WIDTH-1:0] == '0);
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
                S_MUL: begin
                    // Fixed WIDTH-edge latency: the final partial product lands on the last edge.
                    if (w_mul_last) begin
                        r_result <= w_acc_next[WIDTH-1:0];
                        r_cout   <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign zero   = r_zero;
    assign cout   = r_cout;

endmodule

// File: tb/tb_mc_alu.sv
// Directed bench for mc_alu: vector table for ADD/MUL plus reset, busy-start and back-to-back sequences.
module tb_mc_alu;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;

    int total;
    int bad;

    typedef struct {
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_result;
        logic             exp_zero;
        logic             exp_cout;
        int               exp_lat;
    } vec_t;

    vec_t vecs[10];

    mc_alu #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .cout   (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        logic [WIDTH-1:0] held;
        op = v.op;
        a = v.a;
        b = v.b;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("vec%0d busy", idx), 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("vec%0d result", idx), 32'(result), 32'(v.exp_result));
        chk($sformatf("vec%0d zero", idx), 32'(zero), 32'(v.exp_zero));
        chk($sformatf("vec%0d cout", idx), 32'(cout), 32'(v.exp_cout));
        chk($sformatf("vec%0d busy_end", idx), 32'(busy), 32'd0);
        held = result;
        tick();
        chk($sformatf("vec%0d done_pulse", idx), 32'(done), 32'd0);
        chk($sformatf("vec%0d result_hold", idx), 32'(result), 32'(held));
    endtask

    initial begin
        int ndone;
        total = 0;
        bad = 0;

        //          op    a         b         result    z     c     lat
        vecs[0] = '{1'b0, 16'h0003, 16'hFFFD, 16'h0000, 1'b1, 1'b1, 1};
        vecs[1] = '{1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1};
        vecs[2] = '{1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1};
        vecs[4] = '{1'b1, 16'd300,  16'd200,  16'hEA60, 1'b0, 1'b0, 16};
        vecs[5] = '{1'b1, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 16};
        vecs[6] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16};
        vecs[7] = '{1'b1, 16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b0, 16};
        vecs[8] = '{1'b1, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 16};
        vecs[9] = '{1'b1, 16'h1234, 16'h0010, 16'h2340, 1'b0, 1'b1, 16};

        reset = 1'b1;
        start = 1'b0;
        op = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", 32'(result), 32'd0);
        chk("rst zero", 32'(zero), 32'd0);
        chk("rst cout", 32'(cout), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of a multiply: outputs clear at once, no stale done afterwards.
        op = 1'b1;
        a = 16'd300;
        b = 16'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst result", 32'(result), 32'd0);
        chk("midrst zero", 32'(zero), 32'd0);
        chk("midrst cout", 32'(cout), 32'd0);
        tick();
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("midrst no_done", 32'(ndone), 32'd0);
        chk("midrst busy_after", 32'(busy), 32'd0);

        // Start pulses during a multiply must be ignored.
        op = 1'b1;
        a = 16'd300;
        b = 16'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 3 || k == 10) begin
                op = 1'b0;
                a = 16'd1;
                b = 16'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                ndone++;
                chk("busystart done_cycle", 32'(k), 32'd16);
            end
        end
        start = 1'b0;
        chk("busystart ndone", 32'(ndone), 32'd1);
        chk("busystart result", 32'(result), 32'h0000EA60);
        chk("busystart cout", 32'(cout), 32'd0);
        chk("busystart zero", 32'(zero), 32'd0);

        // Start held through done: back-to-back ADDs complete every second cycle.
        op = 1'b0;
        a = 16'd1;
        b = 16'd2;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("b2b done k%0d", k), 32'(done), 32'(k % 2));
            chk($sformatf("b2b result k%0d", k), 32'(result), 32'd3);
        end
        start = 1'b0;
        tick();
        tick();
        chk("b2b idle busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
